// File: rtl/i2c_av_pkg.sv
// i2c_av_pkg: shared states and constants for the I2C register target
package i2c_av_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h1A;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizer, stability filter and edge pulses for one bus line
module i2c_line_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic upd;
  assign upd = (sync[1] != level) && (cnt == CW'(FILT_LEN - 1));
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync <= 2'b11;
      cnt <= '0;
      level <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] == level || upd) ? '0 : cnt + 1'b1;
      level <= upd ? sync[1] : level;
      rise <= upd & sync[1];
      fall <= upd & ~sync[1];
    end
  end
endmodule

// File: rtl/i2c_av_target.sv
// i2c_av_target: oversampled I2C target turning bus frames into register write strobes and read requests
module i2c_av_target import i2c_av_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int FILT_LEN = 4,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_IN,
  output logic       oSDA_OE,
  output logic       oWR_EN,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic [7:0] oRD_ADDR,
  output logic       oRD_REQ,
  input  logic [7:0] iRD_DATA,
  output logic       oBUSY,
  output logic       oBUS_ERR
);
  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic start, stop, mid_byte, rw;
  logic [3:0] cnt;
  logic [7:0] shreg, ptr, rd_buf;
  logic [1:0] req_d;
  state_t state;
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .iCLK(iCLK), .iRST_N(iRST_N), .raw(I2C_SCLK), .level(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .iCLK(iCLK), .iRST_N(iRST_N), .raw(I2C_SDAT_IN), .level(sda), .rise(sda_rise), .fall(sda_fall)
  );
  assign start = sda_fall & scl;
  assign stop = sda_rise & scl;
  // cnt counts SCL rises; START/STOP arrive with SCL high, so one rise is the normal case
  assign mid_byte = (state inside {ADDR, SUB, WDATA, RDATA}) && (cnt > 4'd1);
  assign oRD_ADDR = ptr;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      ptr <= '0;
      rd_buf <= '0;
      rw <= 1'b0;
      req_d <= '0;
      oSDA_OE <= 1'b0;
      oWR_EN <= 1'b0;
      oWR_ADDR <= '0;
      oWR_DATA <= '0;
      oRD_REQ <= 1'b0;
      oBUSY <= 1'b0;
      oBUS_ERR <= 1'b0;
    end else begin
      oWR_EN <= 1'b0;
      oRD_REQ <= 1'b0;
      req_d <= {req_d[0], oRD_REQ};
      if (req_d[1]) rd_buf <= iRD_DATA;
      if (start || stop) begin
        oBUS_ERR <= oBUS_ERR | mid_byte;
        state <= start ? ADDR : IDLE;
        oBUSY <= start & oBUSY;
        oSDA_OE <= 1'b0;
        cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          ADDR, SUB, WDATA: begin
            shreg <= {shreg[6:0], sda};
            cnt <= cnt + 4'd1;
          end
          RDATA: cnt <= cnt + 4'd1;
          ADDR_ACK: oRD_REQ <= rw;
          RDATA_ACK: begin
            state <= (sda == NACK) ? WAIT_STOP : RDATA_ACK;
            oBUSY <= (sda == ACK);
            oRD_REQ <= (sda == ACK);
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR: if (cnt == 4'd8) begin
            cnt <= '0;
            rw <= shreg[0];
            state <= (shreg[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
            oSDA_OE <= (shreg[7:1] == DEV_ADDR);
            oBUSY <= (shreg[7:1] == DEV_ADDR);
          end
          ADDR_ACK: begin
            state <= rw ? RDATA : SUB;
            oSDA_OE <= rw & ~rd_buf[7];
            shreg <= {rd_buf[6:0], 1'b0};
          end
          SUB: if (cnt == 4'd8) begin
            cnt <= '0;
            ptr <= shreg;
            oSDA_OE <= 1'b1;
            state <= SUB_ACK;
          end
          SUB_ACK, WDATA_ACK: begin
            oSDA_OE <= 1'b0;
            state <= WDATA;
          end
          WDATA: if (cnt == 4'd8) begin
            cnt <= '0;
            oWR_EN <= 1'b1;
            oWR_ADDR <= ptr;
            oWR_DATA <= shreg;
            ptr <= ptr + 8'(AUTO_INC);
            oSDA_OE <= 1'b1;
            state <= WDATA_ACK;
          end
          RDATA: if (cnt == 4'd8) begin
            cnt <= '0;
            oSDA_OE <= 1'b0;
            ptr <= ptr + 8'(AUTO_INC);
            state <= RDATA_ACK;
          end else begin
            oSDA_OE <= ~shreg[7];
            shreg <= {shreg[6:0], 1'b0};
          end
          RDATA_ACK: begin
            oSDA_OE <= ~rd_buf[7];
            shreg <= {rd_buf[6:0], 1'b0};
            state <= RDATA;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_av_target.sv
// tb_i2c_av_target: bit-banged I2C master driving directed frames into i2c_av_target
module tb_i2c_av_target;
  import i2c_av_pkg::*;
  localparam int Q = 20;
  localparam int H = 12;
  logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe, wr_en, rd_req, busy, bus_err;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic sda_bus;
  int total = 0, bad = 0, oe_cnt = 0;
  logic [15:0] wr_q[$];
  assign sda_bus = sda_m & ~sda_oe;
  assign rd_data = ~rd_addr;
  always #5 clk = ~clk;
  i2c_av_target dut (
    .iCLK(clk), .iRST_N(rst_n), .I2C_SCLK(scl_m), .I2C_SDAT_IN(sda_bus),
    .oSDA_OE(sda_oe), .oWR_EN(wr_en), .oWR_ADDR(wr_addr), .oWR_DATA(wr_data),
    .oRD_ADDR(rd_addr), .oRD_REQ(rd_req), .iRD_DATA(rd_data), .oBUSY(busy), .oBUS_ERR(bus_err)
  );
  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic i2c_start();
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(H);
  endtask
  task automatic i2c_rstart();
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(H);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b1; cyc(Q);
  endtask
  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b; cyc(Q);
    scl_m = 1'b1;
    if (glitch) begin
      cyc(Q / 2); scl_m = 1'b0; cyc(2); scl_m = 1'b1; cyc(Q / 2);
    end else cyc(Q);
    scl_m = 1'b0; cyc(H);
  endtask
  task automatic read_bit(output logic b);
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q / 2);
    b = sda_bus; cyc(Q / 2);
    scl_m = 1'b0; cyc(H);
  endtask
  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask
  task automatic recv_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    send_bit(ack, 1'b0);
  endtask
  initial begin
    logic a;
    logic [7:0] d;
    int n0, o0;
    cyc(10);
    chk("rst_oe", sda_oe, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_ptr", rd_addr, 8'h00);
    rst_n = 1'b1; cyc(10);
    // single write
    n0 = wr_q.size();
    i2c_start();
    send_byte(8'h34, -1, a); chk("t1_ack_dev", a, 0);
    chk("t1_busy", busy, 1);
    send_byte(8'h0E, -1, a); chk("t1_ack_sub", a, 0);
    send_byte(8'h4A, -1, a); chk("t1_ack_data", a, 0);
    i2c_stop();
    chk("t1_nwr", wr_q.size() - n0, 1);
    if (wr_q.size() > n0) chk("t1_wr", wr_q[n0], 16'h0E4A);
    chk("t1_busy_end", busy, 0);
    // address mismatch
    n0 = wr_q.size(); o0 = oe_cnt;
    i2c_start();
    send_byte(8'h40, -1, a); chk("t2_nack_dev", a, 1);
    send_byte(8'hC3, -1, a);
    send_byte(8'h01, -1, a);
    i2c_stop();
    chk("t2_oe_cycles", oe_cnt - o0, 0);
    chk("t2_nwr", wr_q.size() - n0, 0);
    chk("t2_idle", dut.state == IDLE, 1);
    chk("t2_busy", busy, 0);
    // burst write with pointer wrap
    n0 = wr_q.size();
    i2c_start();
    send_byte(8'h34, -1, a);
    send_byte(8'hFE, -1, a);
    send_byte(8'hA1, -1, a); chk("t3_ack1", a, 0);
    send_byte(8'hA2, -1, a); chk("t3_ack2", a, 0);
    send_byte(8'hA3, -1, a); chk("t3_ack3", a, 0);
    i2c_stop();
    chk("t3_nwr", wr_q.size() - n0, 3);
    if (wr_q.size() >= n0 + 3) begin
      chk("t3_wr0", wr_q[n0], 16'hFEA1);
      chk("t3_wr1", wr_q[n0 + 1], 16'hFFA2);
      chk("t3_wr2", wr_q[n0 + 2], 16'h00A3);
    end
    // write sub-address then read via repeated START
    n0 = wr_q.size();
    i2c_start();
    send_byte(8'h34, -1, a);
    send_byte(8'h10, -1, a); chk("t4_ack_sub", a, 0);
    i2c_rstart();
    send_byte(8'h35, -1, a); chk("t4_ack_rd", a, 0);
    recv_byte(d, 1'b0); chk("t4_rd0", d, 8'hEF);
    recv_byte(d, 1'b1); chk("t4_rd1", d, 8'hEE);
    chk("t4_released", sda_oe, 0);
    i2c_stop();
    chk("t4_idle", dut.state == IDLE, 1);
    chk("t4_nwr", wr_q.size() - n0, 0);
    chk("t4_no_err", bus_err, 0);
    // glitch on SCL, then STOP mid-byte
    n0 = wr_q.size();
    i2c_start();
    send_byte(8'h34, -1, a);
    send_byte(8'h20, -1, a);
    send_byte(8'h5C, 3, a); chk("t5_ack_glitch", a, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    i2c_stop();
    chk("t5_nwr", wr_q.size() - n0, 1);
    if (wr_q.size() > n0) chk("t5_wr", wr_q[n0], 16'h205C);
    chk("t5_err", bus_err, 1);
    chk("t5_busy", busy, 0);
    // async reset while ACK is driven
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 4 || i == 2, 1'b0);
    for (int i = 0; i < 100 && !sda_oe; i++) @(posedge clk);
    chk("t6_ack_driven", sda_oe, 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_oe_reset", sda_oe, 0);
    chk("t6_err_cleared", bus_err, 0);
    sda_m = 1'b1; cyc(5);
    rst_n = 1'b1;
    scl_m = 1'b1; cyc(Q);
    n0 = wr_q.size();
    i2c_start();
    send_byte(8'h34, -1, a); chk("t6_ack_dev", a, 0);
    send_byte(8'h05, -1, a); chk("t6_ack_sub", a, 0);
    send_byte(8'h77, -1, a); chk("t6_ack_data", a, 0);
    i2c_stop();
    chk("t6_nwr", wr_q.size() - n0, 1);
    if (wr_q.size() > n0) chk("t6_wr", wr_q[n0], 16'h0577);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_av_target.md
Name: i2c_av_target

Overview:
- I2C target (slave) responder: the other end of the board's I2C configuration master.
- Decodes frames of the form {device addr, sub-address, data...} and exposes received bytes as register-write strobes.
- Serves register reads via repeated START.
- Used as an on-chip codec/decoder register model for loopback bring-up, and as the reusable target for any FPGA-side I2C-configurable peripheral.
- All logic is synchronous to iCLK. SCL/SDA are oversampled; there is no clocking on SCL.

Parameters:
- DEV_ADDR, 7'h1A: 7-bit device address (8'h34 write / 8'h35 read on the wire).
- FILT_LEN, 4: iCLK cycles a synchronized SCL/SDA level must be stable before it is accepted.
- AUTO_INC, 1: 1 = increment the sub-address pointer after each data byte; 0 = hold it.

Ports:
- iCLK  in  1  system clock, 50 MHz
- iRST_N  in  1  asynchronous active-low reset
- I2C_SCLK  in  1  bus SCL (raw, asynchronous)
- I2C_SDAT_IN  in  1  bus SDA sampled value (raw, asynchronous)
- oSDA_OE  out  1  1 = pull SDA low (open-drain). The top level ties the pad to 1'bz otherwise.
- oWR_EN  out  1  one-cycle write strobe
- oWR_ADDR  out  8  sub-address for the write
- oWR_DATA  out  8  data byte for the write
- oRD_ADDR  out  8  current read pointer, valid while oRD_REQ=1
- oRD_REQ  out  1  one-cycle pulse; iRD_DATA is captured exactly 2 cycles later
- iRD_DATA  in  8  read data for oRD_ADDR
- oBUSY  out  1  high from an addressed START until STOP or NACK-idle
- oBUS_ERR  out  1  sticky; set on START/STOP mid-byte, cleared by reset only

Behaviour:
- Reset (iRST_N=0, async):
  - All outputs 0.
  - FSM = IDLE, pointer = 0.
  - Filtered SCL/SDA = 1.
- Input conditioning:
  - 2-FF synchronizer on each line.
  - Each line then passes a stability filter: the filtered level updates only after FILT_LEN consecutive equal samples.
  - Edge pulses scl_rise and scl_fall are derived from the filtered SCL.
- Bus conditions, each a 1-cycle pulse:
  - START: filtered SDA 1->0 while filtered SCL=1.
  - STOP: filtered SDA 0->1 while filtered SCL=1.
- Sampling and driving:
  - Data bits are sampled MSB-first on scl_rise.
  - oSDA_OE changes only on scl_fall cycles. This guarantees hold of at least (2+FILT_LEN) iCLK after the SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
  - IDLE: START -> ADDR, bit count = 0.
  - ADDR: shift in 8 bits.
    - On the scl_fall after bit 8: if addr[7:1]==DEV_ADDR, go to ADDR_ACK, oSDA_OE=1, oBUSY=1.
    - Otherwise go to WAIT_STOP with oSDA_OE=0 (NACK by silence).
  - ADDR_ACK: on the next scl_fall, release oSDA_OE.
    - R/W=0 -> SUB.
    - R/W=1 -> pulse oRD_REQ with the current pointer, load the shifter from iRD_DATA, drive the first bit (oSDA_OE = ~bit7) on this same scl_fall, then go to RDATA.
  - SUB: shift 8 bits. On the 8th-bit scl_fall: pointer <= byte, oSDA_OE=1, go to SUB_ACK.
  - SUB_ACK: on scl_fall, release and go to WDATA.
  - WDATA: shift 8 bits. On the 8th-bit scl_fall:
    - oWR_EN=1 for one cycle with oWR_ADDR=pointer and oWR_DATA=byte.
    - oSDA_OE=1, go to WDATA_ACK.
    - If AUTO_INC=1, pointer increments with 8-bit wrap (8'hFF -> 8'h00).
  - WDATA_ACK: on scl_fall, release and go back to WDATA (multi-byte writes).
  - RDATA: on each scl_fall, drive the next bit.
    - After 8 bits, release (oSDA_OE=0) and go to RDATA_ACK.
    - If AUTO_INC=1, the pointer increments after each byte.
  - RDATA_ACK: sample the master's bit on scl_rise.
    - ACK (0): oRD_REQ for the next byte; on scl_fall, drive its bit7 and go to RDATA.
    - NACK (1): go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignore bits. STOP -> IDLE; START -> ADDR.
- Global conditions, from any state:
  - STOP -> IDLE, oSDA_OE=0, oBUSY=0.
  - START -> ADDR, which is a repeated START. The pointer is retained, enabling write-sub-address-then-read.
  - START/STOP with bit count 1..7 in ADDR/SUB/WDATA/RDATA also sets oBUS_ERR.
- Simultaneous events: STOP/START take priority over scl edges in the same cycle.
- Partial bytes never produce oWR_EN.
- Reset mid-transfer releases SDA immediately (async).

Decomposition:
- Package i2c_av_pkg:
  - FSM state enum
  - constants ACK=1'b0, NACK=1'b1
  - default DEV_ADDR 7'h1A (matches the master's 8'h34 audio slot)
- Sub-module i2c_line_filter: synchronizer plus stability filter plus edge detect. Instantiated once for SCL and once for SDA, with outputs level, rise and fall.

Test Plan:
1. Single write: master sends 8'h34, 8'h0E, 8'h4A, then STOP.
   - Expected: three ACKs.
   - Expected: exactly one oWR_EN with oWR_ADDR=8'h0E, oWR_DATA=8'h4A.
   - Expected: oBUSY returns to 0 after STOP.
2. Address mismatch: master sends 8'h40, 8'hC3, 8'h01.
   - Expected: SDA is never driven (oSDA_OE=0 throughout).
   - Expected: no oWR_EN; FSM is in IDLE after STOP.
3. Burst write with AUTO_INC=1: 8'h34, 8'hFE, then data 8'hA1, 8'hA2, 8'hA3.
   - Expected: strobes at addresses 8'hFE, 8'hFF, 8'h00 (wrap).
4. Write-then-read: 8'h34, 8'h10, repeated START, 8'h35; the model returns iRD_DATA = ~oRD_ADDR; the master ACKs the first byte and NACKs the second.
   - Expected: bytes 8'hEF then 8'hEE on the bus.
   - Expected: SDA released after the NACK; IDLE after STOP.
5. Glitch and error: insert a 2-cycle SCL glitch (less than FILT_LEN) mid-bit.
   - Expected: ignored; data intact.
   - Then: STOP after 4 bits of the data byte.
   - Expected: oBUS_ERR=1, no oWR_EN.
6. Async reset asserted while the ACK is being driven.
   - Expected: oSDA_OE=0 in the same cycle.
   - Expected: the next complete frame after reset is accepted normally.
